imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
Parametrised, registered immediate generator for the decode stage. It accepts a 32-bit instruction and an immediate-format select under a valid/ready handshake, and produces an XLEN-wide immediate. A 2-entry skid buffer keeps full throughput under backpressure from execute. Compared with the combinational sign-extend block, it adds RV64 support, a CSR zimm format, an illegal-select flag, a pass-through tag and flush.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64 only (elaboration error otherwise).
TAG_W, 5, width of the sideband tag carried alongside the immediate (e.g. rd index).
SHAMT_W (localparam), XLEN==64 ? 6 : 5, shift-amount width for I_TYPE_U.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
flush  in  1  synchronous pipeline flush.
in_valid  in  1  instruction/select valid.
in_ready  out  1  block can accept this cycle.
in_instr  in  32  raw instruction word.
in_sel  in  3  immediate format select (imm_sel_t).
in_tag  in  TAG_W  sideband, passed through unchanged.
out_valid  out  1  output entry valid.
out_ready  in  1  consumer accepts this cycle.
out_imm  out  XLEN  extended immediate.
out_illegal  out  1  in_sel was not a defined format.
out_tag  out  TAG_W  tag of the presented entry.

Behaviour:
- Format decode; sx = replicate instr[31] to fill XLEN:
  - 000 I_TYPE: sx, instr[31:20].
  - 001 I_TYPE_U: zero-extend instr[20+SHAMT_W-1:20].
  - 010 S_TYPE: sx, instr[31:25], instr[11:7].
  - 011 B_TYPE: sx, instr[7], instr[30:25], instr[11:8], 0.
  - 100 J_TYPE: sx, instr[19:12], instr[20], instr[30:21], 0.
  - 101 U_TYPE: sx above bit 31, instr[31:12], 12'b0. For XLEN=32 this is just instr[31:12], 12'b0.
  - 110 Z_TYPE: zero-extend instr[19:15] (CSR uimm).
  - 111: out_imm = 0, out_illegal = 1. Never X. out_illegal = 0 for every defined format.
- Handshake:
  - Accept when in_valid && in_ready.
  - Transfer out when out_valid && out_ready.
  - An entry is held stable (imm, illegal, tag) until transferred.
- Latency: accepted input appears on out_* in the following cycle when the buffer was empty. Throughput is 1 per cycle when out_ready stays high.
- Storage: main register (drives out_*) plus skid register. Occupancy FSM:
  - EMPTY:
    - accept → ONE.
  - ONE:
    - accept without transfer → TWO (new entry goes to skid).
    - transfer without accept → EMPTY.
    - both → ONE (new entry goes to main).
  - TWO:
    - transfer → ONE (skid moves to main).
    - no accept possible in TWO.
- in_ready = (state != TWO). It is a registered-state function with no combinational path from out_ready.
- out_valid = (state != EMPTY).
- Order is strictly FIFO. No entry is dropped or duplicated.
- flush: next state EMPTY, and any same-cycle accept is discarded. flush has priority over accept and transfer. in_ready is unaffected in the flush cycle.
- Reset (asynchronous, any time, including mid-transfer): state EMPTY, out_valid 0, in_ready 1, out_imm 0, out_illegal 0, out_tag 0. Datapath registers are cleared too, so no X is visible after reset.

Decomposition:
- Package imm_pkg:
  - imm_sel_t enum (I_TYPE, I_TYPE_U, S_TYPE, B_TYPE, J_TYPE, U_TYPE, Z_TYPE, ILLEGAL).
  - occupancy state enum (EMPTY, ONE, TWO).
  - Function imm_decode(sel, instr) returning {illegal, imm}, parametrised by XLEN via the caller's width.
- One sub-module: imm_skid_buf, a generic 2-entry valid/ready buffer of width 1+XLEN+TAG_W. It owns the occupancy FSM and flush logic. The top level holds only the decode function plus this buffer.

Test Plan:
- I-type, XLEN=32: in_instr 0xFFF00093, sel 000, out_ready=1 → next cycle out_valid=1, out_imm 0xFFFFFFFF, out_illegal 0.
- B-type: in_instr 0xFE000EE3, sel 011 → out_imm 0xFFFFFFFC. Z_TYPE with in_instr 0x000FD073, sel 110 → out_imm 0x0000001F. sel 111 → out_imm 0, out_illegal 1.
- Backpressure: out_ready=0, in_valid=1 for 3 cycles with tags 1,2,3 → in_ready falls after 2 accepts. Release out_ready → tags 1,2,3 emerge in order on consecutive cycles, none lost.
- Flush: buffer in TWO, assert flush with in_valid=1 → next cycle out_valid=0, state EMPTY, flushed-cycle input absent from output.
- Async reset mid-operation: assert rst between clock edges with TWO entries → out_valid=0 and in_ready=1 immediately, before the next edge. Outputs remain 0 until a new accept.
- XLEN=64: U_TYPE with in_instr 0x800000B7 → out_imm 0xFFFFFFFF80000000. I_TYPE_U with in_instr 0x03F09093 → out_imm 0x3F (6-bit shamt).

Source files
------------

// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - Immediate format/occupancy types and the immediate decode function.
package imm_pkg;

    typedef enum logic [2:0] {
        I_TYPE   = 3'd0,
        I_TYPE_U = 3'd1,
        S_TYPE   = 3'd2,
        B_TYPE   = 3'd3,
        J_TYPE   = 3'd4,
        U_TYPE   = 3'd5,
        Z_TYPE   = 3'd6,
        ILLEGAL  = 3'd7
    } imm_sel_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_state_t;

    // Always builds the 64-bit form; a 32-bit caller keeps the low half.
    function automatic logic [64:0] imm_decode(input imm_sel_t sel, input logic [31:0] instr,
                                               input logic wide_shamt);
        logic [63:0] sx;
        logic [63:0] imm;
        logic        illegal;
        sx      = {64{instr[31]}};
        imm     = '0;
        illegal = 1'b0;
        case (sel)
            I_TYPE:   imm = {sx[63:12], instr[31:20]};
            I_TYPE_U: imm = wide_shamt ? {58'b0, instr[25:20]} : {59'b0, instr[24:20]};
            S_TYPE:   imm = {sx[63:12], instr[31:25], instr[11:7]};
            B_TYPE:   imm = {sx[63:12], instr[7], instr[30:25], instr[11:8], 1'b0};
            J_TYPE:   imm = {sx[63:20], instr[19:12], instr[20], instr[30:21], 1'b0};
            U_TYPE:   imm = {sx[63:32], instr[31:12], 12'b0};
            Z_TYPE:   imm = {59'b0, instr[19:15]};
            default: begin
                imm     = '0;
                illegal = 1'b1;
            end
        endcase
        return {illegal, imm};
    endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// rtl/imm_gen_pipe_if.sv - Instruction-in / immediate-out handshake bundle.
interface imm_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [2:0]       in_sel;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic             out_illegal;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_instr, in_sel, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_illegal, out_tag
    );

    modport slave (
        input  in_valid, in_instr, in_sel, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_illegal, out_tag
    );
endinterface

// File: rtl/imm_skid_buf.sv
// rtl/imm_skid_buf.sv - Generic 2-entry valid/ready skid buffer with flush.
module imm_skid_buf
    import imm_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    occ_state_t   state_q, state_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         in_ready_q;
    logic         out_valid_q;
    logic         acc;
    logic         xfer;

    assign acc  = in_valid && in_ready_q;
    assign xfer = out_valid_q && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (acc) begin
                    main_d  = in_data;
                    state_d = ONE;
                end
                ONE: begin
                    if (acc && !xfer) begin
                        skid_d  = in_data;
                        state_d = TWO;
                    end else if (acc && xfer) begin
                        main_d  = in_data;
                    end else if (xfer) begin
                        state_d = EMPTY;
                    end
                end
                TWO: if (xfer) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // Handshake outputs are registered from the next state, so out_ready never reaches in_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= (state_d != TWO);
            out_valid_q <= (state_d != EMPTY);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;

endmodule

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - Registered immediate generator: format decode feeding a skid buffer.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    imm_gen_pipe_if.slave bus
);

    localparam int SHAMT_W = (XLEN == 64) ? 6 : 5;
    localparam int W       = 1 + XLEN + TAG_W;

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    logic [64:0]     dec_full;
    logic [XLEN-1:0] imm;
    logic [W-1:0]    out_data;
    logic            unused_opcode;

    always_comb begin
        dec_full = imm_decode(imm_sel_t'(bus.in_sel), bus.in_instr, SHAMT_W == 6);
    end

    assign imm           = dec_full[XLEN-1:0];
    assign unused_opcode = ^bus.in_instr[6:0];

    if (XLEN == 32) begin : g_narrow
        logic unused_hi;
        assign unused_hi = ^dec_full[63:32];
    end

    imm_skid_buf #(.W(W)) u_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   ({dec_full[64], imm, bus.in_tag}),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (out_data)
    );

    assign {bus.out_illegal, bus.out_imm, bus.out_tag} = out_data;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - Directed bench for imm_gen_pipe at XLEN=32 and XLEN=64.
module tb_imm_gen_pipe;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32), .TAG_W(5)) b32 ();
    imm_gen_pipe_if #(.XLEN(64), .TAG_W(5)) b64 ();

    imm_gen_pipe #(.XLEN(32), .TAG_W(5)) dut32 (.clk(clk), .rst(rst), .flush(flush), .bus(b32));
    imm_gen_pipe #(.XLEN(64), .TAG_W(5)) dut64 (.clk(clk), .rst(rst), .flush(flush), .bus(b64));

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Presents one instruction with out_ready high and checks it a cycle later.
    task automatic send(input bit w64, input logic [31:0] instr, input logic [2:0] sel,
                        input logic [4:0] tag, input logic [63:0] exp_imm, input logic exp_ill,
                        input string name);
        if (w64) begin
            b64.in_valid = 1'b1; b64.in_instr = instr; b64.in_sel = sel; b64.in_tag = tag;
        end else begin
            b32.in_valid = 1'b1; b32.in_instr = instr; b32.in_sel = sel; b32.in_tag = tag;
        end
        @(negedge clk);
        if (w64) begin
            check_eq({name, ".valid"}, 64'(b64.out_valid), 64'd1);
            check_eq({name, ".imm"}, b64.out_imm, exp_imm);
            check_eq({name, ".ill"}, 64'(b64.out_illegal), 64'(exp_ill));
            check_eq({name, ".tag"}, 64'(b64.out_tag), 64'(tag));
        end else begin
            check_eq({name, ".valid"}, 64'(b32.out_valid), 64'd1);
            check_eq({name, ".imm"}, 64'(b32.out_imm), exp_imm);
            check_eq({name, ".ill"}, 64'(b32.out_illegal), 64'(exp_ill));
            check_eq({name, ".tag"}, 64'(b32.out_tag), 64'(tag));
        end
    endtask

    task automatic push32(input logic [4:0] tag);
        b32.in_valid = 1'b1; b32.in_instr = 32'hFFF00093; b32.in_sel = 3'd0; b32.in_tag = tag;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        b32.in_valid = 1'b0; b32.in_instr = '0; b32.in_sel = '0; b32.in_tag = '0; b32.out_ready = 1'b1;
        b64.in_valid = 1'b0; b64.in_instr = '0; b64.in_sel = '0; b64.in_tag = '0; b64.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("rst.valid", 64'(b32.out_valid), 64'd0);
        check_eq("rst.ready", 64'(b32.in_ready), 64'd1);
        check_eq("rst.imm", 64'(b32.out_imm), 64'd0);
        check_eq("rst.ill", 64'(b32.out_illegal), 64'd0);
        check_eq("rst.tag", 64'(b32.out_tag), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back stream, one per cycle.
        send(0, 32'hFFF00093, 3'd0, 5'd3,  64'hFFFF_FFFF, 1'b0, "i32");
        send(0, 32'hFE000EE3, 3'd3, 5'd4,  64'hFFFF_FFFC, 1'b0, "b32");
        send(0, 32'h000FD073, 3'd6, 5'd5,  64'h0000_001F, 1'b0, "z32");
        send(0, 32'hFFFFFFFF, 3'd7, 5'd6,  64'h0,         1'b1, "ill32");
        send(0, 32'h00112423, 3'd2, 5'd7,  64'h8,         1'b0, "s32");
        send(0, 32'h0080006F, 3'd4, 5'd8,  64'h8,         1'b0, "j32");
        send(0, 32'h800000B7, 3'd5, 5'd9,  64'h8000_0000, 1'b0, "u32");
        send(0, 32'h03F09093, 3'd1, 5'd10, 64'h1F,        1'b0, "sh32");
        b32.in_valid = 1'b0;
        @(negedge clk);
        check_eq("drain.valid", 64'(b32.out_valid), 64'd0);

        // Backpressure: two accepts fill the buffer, third waits.
        b32.out_ready = 1'b0;
        push32(5'd1);
        @(negedge clk);
        check_eq("bp.ready1", 64'(b32.in_ready), 64'd1);
        check_eq("bp.tag1", 64'(b32.out_tag), 64'd1);
        push32(5'd2);
        @(negedge clk);
        check_eq("bp.ready2", 64'(b32.in_ready), 64'd0);
        push32(5'd3);
        @(negedge clk);
        check_eq("bp.hold.ready", 64'(b32.in_ready), 64'd0);
        check_eq("bp.hold.tag", 64'(b32.out_tag), 64'd1);
        b32.out_ready = 1'b1;
        @(negedge clk);
        check_eq("bp.out2", 64'(b32.out_tag), 64'd2);
        check_eq("bp.out2.valid", 64'(b32.out_valid), 64'd1);
        @(negedge clk);
        b32.in_valid = 1'b0;
        check_eq("bp.out3", 64'(b32.out_tag), 64'd3);
        check_eq("bp.out3.valid", 64'(b32.out_valid), 64'd1);
        @(negedge clk);
        check_eq("bp.empty", 64'(b32.out_valid), 64'd0);

        // Flush while full, then flush with a same-cycle accept from ONE.
        b32.out_ready = 1'b0;
        push32(5'd4); @(negedge clk);
        push32(5'd5); @(negedge clk);
        check_eq("fl.full", 64'(b32.in_ready), 64'd0);
        flush = 1'b1; push32(5'd6);
        @(negedge clk);
        flush = 1'b0; b32.in_valid = 1'b0;
        check_eq("fl.valid", 64'(b32.out_valid), 64'd0);
        check_eq("fl.ready", 64'(b32.in_ready), 64'd1);
        push32(5'd7); @(negedge clk);
        check_eq("fl.one", 64'(b32.out_tag), 64'd7);
        flush = 1'b1; push32(5'd8);
        @(negedge clk);
        flush = 1'b0; b32.in_valid = 1'b0;
        check_eq("fl2.valid", 64'(b32.out_valid), 64'd0);
        b32.out_ready = 1'b1;
        @(negedge clk);
        check_eq("fl2.absent", 64'(b32.out_valid), 64'd0);

        // Asynchronous reset between edges with two entries held.
        b32.out_ready = 1'b0;
        push32(5'd9); @(negedge clk);
        push32(5'd10); @(negedge clk);
        b32.in_valid = 1'b0;
        check_eq("ar.full", 64'(b32.in_ready), 64'd0);
        #2 rst = 1'b1;
        #1;
        check_eq("ar.valid", 64'(b32.out_valid), 64'd0);
        check_eq("ar.ready", 64'(b32.in_ready), 64'd1);
        check_eq("ar.imm", 64'(b32.out_imm), 64'd0);
        check_eq("ar.tag", 64'(b32.out_tag), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("ar.after.valid", 64'(b32.out_valid), 64'd0);
        check_eq("ar.after.imm", 64'(b32.out_imm), 64'd0);
        b32.out_ready = 1'b1;

        // 64-bit datapath.
        send(1, 32'h800000B7, 3'd5, 5'd11, 64'hFFFF_FFFF_8000_0000, 1'b0, "u64");
        send(1, 32'h03F09093, 3'd1, 5'd12, 64'h3F,                  1'b0, "sh64");
        send(1, 32'hFFF00093, 3'd0, 5'd13, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, "i64");
        send(1, 32'h80000000, 3'd7, 5'd14, 64'h0,                   1'b1, "ill64");
        b64.in_valid = 1'b0;
        @(negedge clk);
        check_eq("drain64.valid", 64'(b64.out_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
